// File: rtl/fifo_wr_ptr_ctrl_if.sv
`default_nettype none
// fifo_wr_ptr_ctrl_if: push handshake, synchronised read pointer and status bundle
// for the async-FIFO write-side pointer controller.  Rev 1.0
interface fifo_wr_ptr_ctrl_if #(
   parameter int ADDR_WIDTH = 3
);
   logic                  i_wr_en;
   logic [ADDR_WIDTH:0]   i_rd_ptr_gray_sync;
   logic [ADDR_WIDTH-1:0] o_wr_addr;
   logic                  o_wr_valid;
   logic [ADDR_WIDTH:0]   o_wr_ptr_gray;
   logic                  o_full;
   logic                  o_almost_full;
   logic [ADDR_WIDTH:0]   o_fill_level;
   logic                  o_overflow;

   modport master (
      output i_wr_en,
      output i_rd_ptr_gray_sync,
      input  o_wr_addr,
      input  o_wr_valid,
      input  o_wr_ptr_gray,
      input  o_full,
      input  o_almost_full,
      input  o_fill_level,
      input  o_overflow
   );

   modport slave (
      input  i_wr_en,
      input  i_rd_ptr_gray_sync,
      output o_wr_addr,
      output o_wr_valid,
      output o_wr_ptr_gray,
      output o_full,
      output o_almost_full,
      output o_fill_level,
      output o_overflow
   );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_ptr_ctrl.sv
`default_nettype none
// fifo_wr_ptr_ctrl: write-domain binary/Gray pointer with full, almost-full,
// fill-level and overflow status against the synchronised read pointer.  Rev 1.0
module fifo_wr_ptr_ctrl #(
   parameter int ADDR_WIDTH   = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   fifo_wr_ptr_ctrl_if.slave bus
);
   localparam int                PTR_W     = ADDR_WIDTH + 1;
   localparam int                MSB       = ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

   logic [ADDR_WIDTH:0] bin;
   logic [ADDR_WIDTH:0] bin_next;
   logic [ADDR_WIDTH:0] gray_next;
   logic [ADDR_WIDTH:0] rg;
   logic [ADDR_WIDTH:0] rbin;
   logic [ADDR_WIDTH:0] full_gray;
   logic [ADDR_WIDTH:0] level_next;
   logic                push;

   assign rg       = bus.i_rd_ptr_gray_sync;
   assign push     = bus.i_wr_en & ~bus.o_full;
   assign bin_next = bin + {{ADDR_WIDTH{1'b0}}, push};
   assign gray_next = bin_next ^ (bin_next >> 1);

   // Full when the write pointer is exactly one lap ahead: in Gray this is the
   // read pointer with its two top bits inverted.
   assign full_gray = {~rg[MSB], ~rg[MSB-1], rg[MSB-2:0]};

   always_comb begin
      rbin = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) begin
         rbin[i] = ^(rg >> i);
      end
   end

   // Stale read pointer can only under-count reads, so this never under-reports.
   assign level_next = bin_next - rbin;

   assign bus.o_wr_addr  = bin[ADDR_WIDTH-1:0];
   assign bus.o_wr_valid = push;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bin               <= '0;
         bus.o_wr_ptr_gray <= '0;
         bus.o_full        <= 1'b0;
         bus.o_almost_full <= 1'b0;
         bus.o_fill_level  <= '0;
         bus.o_overflow    <= 1'b0;
      end else begin
         bin               <= bin_next;
         bus.o_wr_ptr_gray <= gray_next;
         bus.o_full        <= (gray_next == full_gray);
         bus.o_almost_full <= (level_next >= AFULL_LVL);
         bus.o_fill_level  <= level_next;
         bus.o_overflow    <= bus.i_wr_en & bus.o_full;
      end
   end
endmodule
`default_nettype wire
